// File: rtl/uart_reg_bridge_pkg.sv
// rtl/uart_reg_bridge_pkg.sv - shared command codes, reply codes and FSM encoding for uart_reg_bridge
//
// Purpose : constants and state type shared by the UART register bridge.
// Contents: CMD_WR / CMD_RD command bytes, RSP_ACK / RSP_NAK reply bytes,
//           state_t encoding, and a helper that flags the timeout-guarded states.

package uart_reg_bridge_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_W_ADDR = 3'd1,
      ST_W_DATA = 3'd2,
      ST_REG_WR = 3'd3,
      ST_R_ADDR = 3'd4,
      ST_REG_RD = 3'd5,
      ST_RD_CAP = 3'd6,
      ST_SEND   = 3'd7
   } state_t;

   // States that sit inside a frame waiting for the next byte; only these
   // run the inter-byte timeout.
   function automatic logic is_timed(input state_t s);
      return (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
   endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART command-frame to register-bus bridge
//
// Purpose : decodes 0x57/addr/data (write) and 0x52/addr (read) frames received
//           from the UART into single-cycle register accesses and sends one
//           reply byte per frame (ACK, read data, or NAK).
// Ports   :
//   clk_50m      in   system clock (shared with the UART)
//   rst          in   synchronous active-high reset
//   rx_data[7:0] in   received byte (UART dout)
//   rx_rdy       in   received byte valid, held until cleared (UART rdy)
//   rx_rdy_clr   out  one-cycle consume pulse (UART rdy_clr)
//   tx_data[7:0] out  reply byte (UART din)
//   tx_wr_en     out  one-cycle transmit request (UART wr_en)
//   tx_busy      in   transmitter busy (UART)
//   reg_addr     out  register address, held between frames
//   reg_wdata    out  register write data, held between frames
//   reg_wr       out  one-cycle write strobe
//   reg_rd       out  one-cycle read strobe
//   reg_rdata    in   read data, valid the cycle after reg_rd
//   frame_err    out  one-cycle pulse on bad command byte or inter-byte timeout

module uart_reg_bridge
   import uart_reg_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   output logic       rx_rdy_clr,
   output logic [7:0] tx_data,
   output logic       tx_wr_en,
   input  logic       tx_busy,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       frame_err
);

   // A zero timeout still needs a legal 1-bit counter.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);
   localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             timed;
   logic             take;
   logic             bad_cmd;
   logic             timeout_hit;
   logic             clr_q;
   logic             nak_q;
   logic [7:0]       tx_hold;
   logic [7:0]       addr_q;
   logic [7:0]       wdata_q;

   assign timed   = is_timed(state);

   // The registered clear is still high in the cycle after a consume while
   // rx_rdy may not have fallen yet; masking with it avoids taking the byte twice.
   assign take    = rx_rdy && !clr_q && !rst && (timed || (state == ST_IDLE));
   assign bad_cmd = (rx_data != CMD_WR) && (rx_data != CMD_RD);

   // cnt_inc is the number of cycles spent in the current wait once this
   // cycle ends; the timeout fires in the cycle that count reaches the limit,
   // so exactly TIMEOUT_CYCLES cycles follow the last consume or state entry.
   assign cnt_inc     = {1'b0, to_cnt} + CNT_ONE;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && timed && !take && !rst &&
                        (cnt_inc == TO_LIMIT);

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      reg_wr    = 1'b0;
      reg_rd    = 1'b0;
      tx_wr_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (take) begin
               if (rx_data == CMD_WR) begin
                  state_nxt = ST_W_ADDR;
               end else if (rx_data == CMD_RD) begin
                  state_nxt = ST_R_ADDR;
               end else begin
                  state_nxt = ST_SEND;
               end
            end
         end
         ST_W_ADDR: begin
            if (take) begin
               state_nxt = ST_W_DATA;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_W_DATA: begin
            if (take) begin
               state_nxt = ST_REG_WR;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_R_ADDR: begin
            if (take) begin
               state_nxt = ST_REG_RD;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_REG_WR: begin
            reg_wr    = !rst;
            state_nxt = ST_SEND;
         end
         ST_REG_RD: begin
            reg_rd    = !rst;
            state_nxt = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            // Leaving on the same cycle as the request guarantees one pulse per frame.
            if (!tx_busy) begin
               tx_wr_en  = !rst;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (take || (state_nxt != state) || !timed) begin
         to_cnt <= '0;
      end else if (cnt_inc <= TO_LIMIT) begin
         to_cnt <= cnt_inc[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         clr_q   <= 1'b0;
         nak_q   <= 1'b0;
         tx_hold <= 8'h00;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
      end else begin
         clr_q <= take;
         nak_q <= (state == ST_IDLE) && take && bad_cmd;
         if ((state == ST_IDLE) && take && bad_cmd) begin
            tx_hold <= RSP_NAK;
         end
         if (((state == ST_W_ADDR) || (state == ST_R_ADDR)) && take) begin
            addr_q <= rx_data;
         end
         if ((state == ST_W_DATA) && take) begin
            wdata_q <= rx_data;
         end
         if (state == ST_REG_WR) begin
            tx_hold <= RSP_ACK;
         end
         if (state == ST_RD_CAP) begin
            tx_hold <= reg_rdata;
         end
      end
   end

   assign rx_rdy_clr = clr_q;
   assign tx_data    = tx_hold;
   assign reg_addr   = addr_q;
   assign reg_wdata  = wdata_q;
   assign frame_err  = nak_q || timeout_hit;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - directed self-checking bench for uart_reg_bridge
//
// Purpose : drives command frames through a behavioural UART/register-file
//           model and checks replies, strobes and timing against hand values.

module tb_uart_reg_bridge;

   localparam int TO = 100;

   logic       clk_50m = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdy = 1'b0;
   logic       rx_rdy_clr;
   logic [7:0] tx_data;
   logic       tx_wr_en;
   logic       tx_busy = 1'b0;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata = 8'h00;
   logic       frame_err;

   always #10 clk_50m = ~clk_50m;

   uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .rx_rdy_clr(rx_rdy_clr),
      .tx_data   (tx_data),
      .tx_wr_en  (tx_wr_en),
      .tx_busy   (tx_busy),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .frame_err (frame_err)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   int         tx_cyc[$];
   logic [7:0] wr_a[$];
   logic [7:0] wr_d[$];
   int         wr_cyc[$];
   logic [7:0] rd_a[$];
   int         rd_cyc[$];
   int         err_cyc[$];
   int         clr_cyc[$];
   logic [7:0] mem[256];
   logic       rd_pend = 1'b0;
   logic [7:0] rd_val = 8'h00;
   int         auto_busy = 0;
   int         busy_cnt = 0;
   bit         manual_busy = 1'b0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
   end

   always @(posedge clk_50m) cyc++;

   // Monitor and register-file write/read-capture, sampled mid-cycle.
   always @(negedge clk_50m) begin
      if (tx_wr_en) begin
         tx_q.push_back(tx_data);
         tx_cyc.push_back(cyc);
         if (auto_busy > 0) busy_cnt = auto_busy;
      end
      if (reg_wr) begin
         wr_a.push_back(reg_addr);
         wr_d.push_back(reg_wdata);
         wr_cyc.push_back(cyc);
         mem[reg_addr] = reg_wdata;
      end
      if (reg_rd) begin
         rd_a.push_back(reg_addr);
         rd_cyc.push_back(cyc);
         rd_val  = mem[reg_addr];
         rd_pend = 1'b1;
      end
      if (frame_err) err_cyc.push_back(cyc);
      if (rx_rdy_clr) clr_cyc.push_back(cyc);
   end

   // UART receive side, transmitter busy and 1-cycle register read latency.
   always @(posedge clk_50m) begin
      #1;
      if (rx_rdy_clr) rx_rdy = 1'b0;
      if (!rx_rdy && rx_q.size() > 0) begin
         rx_data = rx_q.pop_front();
         rx_rdy  = 1'b1;
      end
      if (rd_pend) begin
         reg_rdata = rd_val;
         rd_pend   = 1'b0;
      end
      tx_busy = manual_busy || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
   end

   function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 8'hxx;
   endfunction

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic clear_logs();
      tx_q.delete(); tx_cyc.delete(); wr_a.delete(); wr_d.delete(); wr_cyc.delete();
      rd_a.delete(); rd_cyc.delete(); err_cyc.delete(); clr_cyc.delete();
   endtask

   task automatic wait_tx(input int n, input int budget, output bit ok);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         @(negedge clk_50m);
         k++;
      end
      ok = (tx_q.size() >= n);
      repeat (10) @(negedge clk_50m);
   endtask

   task automatic test_reset();
      logic [4:0] strobes;
      rst = 1'b1;
      repeat (3) @(negedge clk_50m);
      strobes = {rx_rdy_clr, tx_wr_en, reg_wr, reg_rd, frame_err};
      checks++;
      if (strobes !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", strobes); end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
      checks++;
      if ({reg_addr, reg_wdata} !== 16'h0000) begin
         errors++; $display("FAIL reset_reg_bus: got %02h/%02h want 00/00", reg_addr, reg_wdata);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk_50m);
   endtask

   task automatic test_write();
      bit ok;
      clear_logs();
      rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5);
      wait_tx(1, 300, ok);
      checks++;
      if (!ok || tx_q.size() != 1) begin errors++; $display("FAIL write_reply_count: got %0d want 1", tx_q.size()); end
      checks++;
      if (qb(tx_q, 0) !== 8'h06) begin errors++; $display("FAIL write_ack: got %02h want 06", qb(tx_q, 0)); end
      checks++;
      if (wr_a.size() != 1 || qb(wr_a, 0) !== 8'h10 || qb(wr_d, 0) !== 8'hA5) begin
         errors++; $display("FAIL write_strobe: got n=%0d %02h/%02h want n=1 10/A5", wr_a.size(), qb(wr_a, 0), qb(wr_d, 0));
      end
      checks++;
      if (qi(wr_cyc, 0) != qi(clr_cyc, 2) || qi(tx_cyc, 0) != qi(clr_cyc, 2) + 1) begin
         errors++; $display("FAIL write_timing: got wr=%0d tx=%0d want %0d/%0d", qi(wr_cyc, 0), qi(tx_cyc, 0), qi(clr_cyc, 2), qi(clr_cyc, 2) + 1);
      end
      checks++;
      if (rd_a.size() != 0 || err_cyc.size() != 0) begin
         errors++; $display("FAIL write_side_effects: got rd=%0d err=%0d want 0/0", rd_a.size(), err_cyc.size());
      end
   endtask

   task automatic test_read();
      bit ok;
      clear_logs();
      rx_q.push_back(8'h52); rx_q.push_back(8'h10);
      wait_tx(1, 300, ok);
      checks++;
      if (!ok || tx_q.size() != 1 || qb(tx_q, 0) !== 8'hA5) begin
         errors++; $display("FAIL read_reply: got n=%0d %02h want n=1 A5", tx_q.size(), qb(tx_q, 0));
      end
      checks++;
      if (rd_a.size() != 1 || qb(rd_a, 0) !== 8'h10 || wr_a.size() != 0) begin
         errors++; $display("FAIL read_strobe: got rd=%0d %02h wr=%0d want 1 10 0", rd_a.size(), qb(rd_a, 0), wr_a.size());
      end
      checks++;
      if (qi(rd_cyc, 0) != qi(clr_cyc, 1) || qi(tx_cyc, 0) != qi(clr_cyc, 1) + 2) begin
         errors++; $display("FAIL read_timing: got rd=%0d tx=%0d want %0d/%0d", qi(rd_cyc, 0), qi(tx_cyc, 0), qi(clr_cyc, 1), qi(clr_cyc, 1) + 2);
      end
   endtask

   task automatic test_bad_cmd();
      bit ok;
      clear_logs();
      rx_q.push_back(8'h41);
      wait_tx(1, 300, ok);
      checks++;
      if (!ok || tx_q.size() != 1 || qb(tx_q, 0) !== 8'h15) begin
         errors++; $display("FAIL bad_nak: got n=%0d %02h want n=1 15", tx_q.size(), qb(tx_q, 0));
      end
      checks++;
      if (err_cyc.size() != 1 || qi(err_cyc, 0) != qi(clr_cyc, 0) || qi(tx_cyc, 0) != qi(clr_cyc, 0)) begin
         errors++; $display("FAIL bad_err_timing: got n=%0d err=%0d tx=%0d want n=1 at %0d", err_cyc.size(), qi(err_cyc, 0), qi(tx_cyc, 0), qi(clr_cyc, 0));
      end
      checks++;
      if (wr_a.size() != 0 || rd_a.size() != 0) begin
         errors++; $display("FAIL bad_no_access: got wr=%0d rd=%0d want 0/0", wr_a.size(), rd_a.size());
      end
      clear_logs();
      rx_q.push_back(8'h57); rx_q.push_back(8'h11); rx_q.push_back(8'h3C);
      wait_tx(1, 300, ok);
      checks++;
      if (tx_q.size() != 1 || qb(tx_q, 0) !== 8'h06 || qb(wr_d, 0) !== 8'h3C || err_cyc.size() != 0) begin
         errors++; $display("FAIL bad_recover: got tx=%02h wd=%02h err=%0d want 06 3C 0", qb(tx_q, 0), qb(wr_d, 0), err_cyc.size());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int k = 0;
      clear_logs();
      rx_q.push_back(8'h57); rx_q.push_back(8'h20);
      while (clr_cyc.size() < 2 && k < 100) begin @(negedge clk_50m); k++; end
      repeat (TO + 50) @(negedge clk_50m);
      checks++;
      if (err_cyc.size() != 1 || qi(err_cyc, 0) - qi(clr_cyc, 1) != TO - 1) begin
         errors++; $display("FAIL timeout_err: got n=%0d delta=%0d want n=1 delta=%0d", err_cyc.size(), qi(err_cyc, 0) - qi(clr_cyc, 1), TO - 1);
      end
      checks++;
      if (tx_q.size() != 0 || wr_a.size() != 0) begin
         errors++; $display("FAIL timeout_silent: got tx=%0d wr=%0d want 0/0", tx_q.size(), wr_a.size());
      end
      clear_logs();
      rx_q.push_back(8'h52); rx_q.push_back(8'h20);
      wait_tx(1, 300, ok);
      checks++;
      if (tx_q.size() != 1 || qb(tx_q, 0) !== 8'h7A || qb(rd_a, 0) !== 8'h20) begin
         errors++; $display("FAIL timeout_recover: got n=%0d %02h addr=%02h want 1 7A 20", tx_q.size(), qb(tx_q, 0), qb(rd_a, 0));
      end
   endtask

   task automatic test_busy();
      bit ok;
      int drop;
      clear_logs();
      @(negedge clk_50m);
      manual_busy = 1'b1;
      rx_q.push_back(8'h52); rx_q.push_back(8'h10);
      repeat (500) @(negedge clk_50m);
      checks++;
      if (tx_q.size() != 0 || rd_a.size() != 1) begin
         errors++; $display("FAIL busy_hold: got tx=%0d rd=%0d want 0/1", tx_q.size(), rd_a.size());
      end
      manual_busy = 1'b0;
      drop = cyc + 1;
      wait_tx(1, 50, ok);
      checks++;
      if (tx_q.size() != 1 || qb(tx_q, 0) !== 8'hA5 || qi(tx_cyc, 0) != drop) begin
         errors++; $display("FAIL busy_release: got n=%0d %02h at %0d want 1 A5 at %0d", tx_q.size(), qb(tx_q, 0), qi(tx_cyc, 0), drop);
      end
      checks++;
      if (err_cyc.size() != 0) begin errors++; $display("FAIL busy_no_timeout: got %0d want 0", err_cyc.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] frames[13];
      logic [7:0] exp[6];
      frames = '{8'h57, 8'h40, 8'h11, 8'h52, 8'h40, 8'h33, 8'h57, 8'h41, 8'h22, 8'h52, 8'h41, 8'h52, 8'h10};
      exp    = '{8'h06, 8'h11, 8'h15, 8'h06, 8'h22, 8'hA5};
      clear_logs();
      auto_busy = 12;
      foreach (frames[i]) rx_q.push_back(frames[i]);
      wait_tx(6, 3000, ok);
      checks++;
      if (tx_q.size() != 6) begin errors++; $display("FAIL b2b_reply_count: got %0d want 6", tx_q.size()); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (qb(tx_q, i) !== exp[i]) begin
            errors++; $display("FAIL b2b_reply[%0d]: got %02h want %02h", i, qb(tx_q, i), exp[i]);
         end
      end
      checks++;
      if (clr_cyc.size() != 13 || wr_a.size() != 2 || rd_a.size() != 3 || err_cyc.size() != 1) begin
         errors++; $display("FAIL b2b_counts: got clr=%0d wr=%0d rd=%0d err=%0d want 13/2/3/1", clr_cyc.size(), wr_a.size(), rd_a.size(), err_cyc.size());
      end
      auto_busy = 0;
      repeat (20) @(negedge clk_50m);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k = 0;
      logic [4:0] strobes;
      clear_logs();
      rx_q.push_back(8'h57); rx_q.push_back(8'h30);
      while (clr_cyc.size() < 2 && k < 100) begin @(negedge clk_50m); k++; end
      repeat (3) @(negedge clk_50m);
      rst = 1'b1;
      @(negedge clk_50m);
      strobes = {rx_rdy_clr, tx_wr_en, reg_wr, reg_rd, frame_err};
      checks++;
      if (strobes !== 5'b0 || reg_addr !== 8'h00 || reg_wdata !== 8'h00 || tx_data !== 8'h00) begin
         errors++; $display("FAIL midreset_outputs: got %b %02h %02h %02h want 00000 00 00 00", strobes, reg_addr, reg_wdata, tx_data);
      end
      rx_q.push_back(8'h52); rx_q.push_back(8'h30);
      repeat (4) @(negedge clk_50m);
      rst = 1'b0;
      wait_tx(1, 300, ok);
      checks++;
      if (tx_q.size() != 1 || qb(tx_q, 0) !== 8'h6A || qb(rd_a, 0) !== 8'h30) begin
         errors++; $display("FAIL midreset_next_frame: got n=%0d %02h addr=%02h want 1 6A 30", tx_q.size(), qb(tx_q, 0), qb(rd_a, 0));
      end
      checks++;
      if (wr_a.size() != 0 || err_cyc.size() != 0) begin
         errors++; $display("FAIL midreset_abandon: got wr=%0d err=%0d want 0/0", wr_a.size(), err_cyc.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_cmd();
      test_timeout();
      test_busy();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
